pwm_servo_array: RTL and testbench
==================================

PWM_SERVO_ARRAY -- requirements
Module: pwm_servo_array

Interface
REQ-001 SHALL provide parameter NUM_CH, default 3: number of servo channels (1..8).
REQ-002 SHALL provide parameter ANGLE_W, default 7: width of each angle code.
REQ-003 SHALL provide parameter ANGLE_MAX, default 127: largest legal angle code (<= 2^ANGLE_W-1).
REQ-004 SHALL provide parameter CLK_HZ, default 50_000_000: clk frequency.
REQ-005 SHALL provide parameter PWM_HZ, default 50: frame rate; PERIOD = CLK_HZ/PWM_HZ cycles.
REQ-006 SHALL provide parameter MIN_US, default 1000: pulse width at angle 0; MIN_CYC = CLK_HZ/1_000_000*MIN_US.
REQ-007 SHALL provide parameter MAX_US, default 2000: pulse width at ANGLE_MAX; MAX_CYC likewise; MAX_CYC < PERIOD is required.
REQ-008 SHALL provide parameter STEP, default 4: maximum angle change per channel per frame (>= 1).
REQ-009 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-010 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-011 SHALL have ports: enable  in  NUM_CH  per-channel pulse enable.
REQ-012 SHALL have ports: angle_in  in  NUM_CH*ANGLE_W  packed targets; channel i at bits [i*ANGLE_W +: ANGLE_W].
REQ-013 SHALL have ports: load  in  1  one-cycle strobe capturing all of angle_in.
REQ-014 SHALL have ports: pwm_out  out  NUM_CH  registered servo pulses.
REQ-015 SHALL have ports: busy  out  1  high while any channel's current angle differs from its target.
REQ-016 SHALL have ports: frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

Function
REQ-017 SHALL run one shared frame counter cnt, 0..PERIOD-1, wrapping to 0.
REQ-018 SHALL, on a clk edge with load=1, store each target as min(angle_in[i], ANGLE_MAX).
REQ-019 SHALL raise frame_tick for exactly the cycle where cnt==PERIOD-1.
REQ-020 SHALL, on the edge where cnt wraps to 0 (the frame boundary), update each channel's current angle cur[i]: if |target-cur| <= STEP then cur=target, else cur moves STEP toward target.
REQ-021 SHALL, at the same boundary, latch W[i] = MIN_CYC + floor(cur_new*(MAX_CYC-MIN_CYC)/ANGLE_MAX) when enable[i]=1, else W[i]=0.
REQ-022 SHALL drive pwm_out[i] high exactly for the cycles in which cnt is in [0, W[i]-1], and low otherwise.
REQ-023 SHALL ensure W[i] and the enable sample change only at frame boundaries, so no truncated or partial pulse is ever emitted.
REQ-024 SHALL, when a load coincides with a boundary edge, apply the new target only from the next boundary; the current boundary uses the previous target.
REQ-025 SHALL keep cur[i] tracking its target while enable[i]=0; the pulse resumes at the next boundary after enable[i] rises.
REQ-026 SHALL compute busy combinationally from registers as the OR over channels of (cur[i] != target[i]).
REQ-027 SHALL implement each channel as a state machine with states HOLD (cur==target) and SLEW (cur!=target).
REQ-028 SHALL move a channel HOLD->SLEW on a load that changes its target, and SLEW->HOLD at the boundary where cur reaches the target.

Reset
REQ-029 SHALL, while rst=0, asynchronously force cnt=0, pwm_out=0, frame_tick=0, W=0, cur=target=ANGLE_MAX/2 (floor), and every channel to HOLD.
REQ-030 SHALL emit no pulse in the first frame after reset release; pulses start at the first boundary.
REQ-031 SHALL, on reset asserted mid-pulse, drop pwm_out to 0 immediately and discard any slew in progress.

Configuration
REQ-032 SHALL, with macro PWM_SERVO_SLEW_EN defined, limit motion by STEP as in REQ-020.
REQ-033 SHALL, without PWM_SERVO_SLEW_EN, set cur=target at every boundary, so busy is high only from load until the next boundary; STEP is then ignored.

Verification
Bench parameters: CLK_HZ=1_000_000, PWM_HZ=400 (PERIOD=2500), MIN_US=1000, MAX_US=2000, ANGLE_MAX=127, STEP=16, NUM_CH=3, all enable=1.
REQ-034 SHALL check: reset release -> no pulse in frame 0; frame 1 pulses are 1496 cycles (angle 63) on all channels; frame_tick period is 2500 cycles.
REQ-035 SHALL check: load ch0=127 with slew enabled -> ch0 widths 1622, 1748, 1874, 2000 over frames; busy drops at the 4th boundary.
REQ-036 SHALL check: load ch1=127 without slew -> ch1 pulse is 2000 cycles next frame; busy is high for exactly one boundary interval.
REQ-037 SHALL check: angle_in ch2=0x7F then ch2=0 with ANGLE_MAX=100 -> targets clamp to 100; ch2 reaches a 1000-cycle pulse.
REQ-038 SHALL check: enable[0] falls mid-pulse -> the current pulse completes at full width; the next frame ch0 stays low; re-enabling resumes at the next boundary.
REQ-039 SHALL check: load on the cycle where frame_tick=1 -> that boundary ignores the new target; change appears one frame later.

Source files
------------

// File: rtl/pwm_servo_array.sv
// -----------------------------------------------------------------------------
// pwm_servo_array
//   Multi-channel hobby-servo PWM generator. All channels share one frame
//   counter. At every frame boundary each channel's current angle steps toward
//   its target. The pulse width for the coming frame is latched at the same
//   boundary, so a width or enable change never truncates a pulse.
//
//   Optional feature (compile-time macro):
//     PWM_SERVO_SLEW_EN  defined   : cur moves at most STEP codes per frame
//                        undefined : cur jumps to target at every boundary
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   enable      in   [NUM_CH]          per-channel pulse enable, sampled at boundaries
//   angle_in    in   [NUM_CH*ANGLE_W]  packed targets, ch i at [i*ANGLE_W +: ANGLE_W]
//   load        in   one-cycle strobe that captures all targets (clamped to ANGLE_MAX)
//   pwm_out     out  [NUM_CH]          registered servo pulses
//   busy        out  high while any channel's current angle differs from its target
//   frame_tick  out  high on the last cycle of each frame
// -----------------------------------------------------------------------------
module pwm_servo_array #(
   parameter int NUM_CH    = 3,
   parameter int ANGLE_W   = 7,
   parameter int ANGLE_MAX = 127,
   parameter int CLK_HZ    = 50_000_000,
   parameter int PWM_HZ    = 50,
   parameter int MIN_US    = 1000,
   parameter int MAX_US    = 2000,
   parameter int STEP      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         enable,
   input  logic [NUM_CH*ANGLE_W-1:0] angle_in,
   input  logic                      load,
   output logic [NUM_CH-1:0]         pwm_out,
   output logic                      busy,
   output logic                      frame_tick
);

   localparam int PERIOD  = CLK_HZ / PWM_HZ;
   localparam int MIN_CYC = CLK_HZ / 1_000_000 * MIN_US;
   localparam int MAX_CYC = CLK_HZ / 1_000_000 * MAX_US;
   localparam int CNT_W   = $clog2(PERIOD);

`ifdef PWM_SERVO_SLEW_EN
   localparam bit SLEW_ON = 1'b1;
`else
   localparam bit SLEW_ON = 1'b0;
`endif
   // Without slew limiting, a limit larger than any possible angle difference
   // makes every boundary land exactly on the target.
   localparam int LIMIT = SLEW_ON ? STEP : (1 << ANGLE_W);

   localparam logic [ANGLE_W-1:0] AMAX = ANGLE_W'(ANGLE_MAX);
   localparam logic [ANGLE_W-1:0] HALF = ANGLE_W'(ANGLE_MAX / 2);

   typedef enum logic {HOLD = 1'b0, SLEW = 1'b1} ch_state_e;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ANGLE_W-1:0] cur_q [NUM_CH];
   logic [ANGLE_W-1:0] cur_d [NUM_CH];
   logic [ANGLE_W-1:0] tgt_q [NUM_CH];
   logic [ANGLE_W-1:0] tgt_d [NUM_CH];
   logic [CNT_W-1:0]   w_q   [NUM_CH];
   logic [CNT_W-1:0]   w_d   [NUM_CH];
   ch_state_e          state_q [NUM_CH];
   ch_state_e          state_d [NUM_CH];
   logic [NUM_CH-1:0]  pwm_q, pwm_d;
   logic               boundary;

   // Pulse width in clock cycles for a given angle code.
   function automatic logic [CNT_W-1:0] width_of(input logic [ANGLE_W-1:0] a);
      logic [31:0] span;
      span = 32'(a) * 32'(MAX_CYC - MIN_CYC) / 32'(ANGLE_MAX);
      return CNT_W'(32'(MIN_CYC) + span);
   endfunction

   // One slew step of at most LIMIT codes from cur toward tgt.
   function automatic logic [ANGLE_W-1:0] step_toward(input logic [ANGLE_W-1:0] cur,
                                                      input logic [ANGLE_W-1:0] tgt);
      int c;
      int t;
      c = int'(cur);
      t = int'(tgt);
      if (t - c > LIMIT)      return ANGLE_W'(c + LIMIT);
      else if (c - t > LIMIT) return ANGLE_W'(c - LIMIT);
      else                    return tgt;
   endfunction

   assign boundary   = (cnt_q == CNT_W'(PERIOD - 1));
   assign frame_tick = boundary;
   assign cnt_d      = boundary ? '0 : cnt_q + 1'b1;
   assign pwm_out    = pwm_q;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      for (int i = 0; i < NUM_CH; i++) begin
         tgt_d[i]   = tgt_q[i];
         cur_d[i]   = cur_q[i];
         w_d[i]     = w_q[i];
         state_d[i] = state_q[i];

         if (load) begin
            tgt_d[i] = (angle_in[i*ANGLE_W +: ANGLE_W] > AMAX) ? AMAX
                                                               : angle_in[i*ANGLE_W +: ANGLE_W];
         end

         // The boundary works from tgt_q, so a load landing on the same edge
         // only takes effect at the following boundary.
         if (boundary) begin
            if (state_q[i] == SLEW) cur_d[i] = step_toward(cur_q[i], tgt_q[i]);
            w_d[i] = enable[i] ? width_of(cur_d[i]) : '0;
         end

         case (state_q[i])
            HOLD:    if (tgt_d[i] != cur_d[i]) state_d[i] = SLEW;
            SLEW:    if (tgt_d[i] == cur_d[i]) state_d[i] = HOLD;
            default: state_d[i] = HOLD;
         endcase

         // Computed from next-cycle values so the registered pulse lines up
         // exactly with cnt in [0, W-1].
         pwm_d[i] = (cnt_d < w_d[i]);
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NUM_CH; i++) busy = busy | (cur_q[i] != tgt_q[i]);
   end

   // NOTE: sequential state uses non-blocking assignments only; the small
   // per-channel register arrays are reset like any other flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         pwm_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cur_q[i]   <= HALF;
            tgt_q[i]   <= HALF;
            w_q[i]     <= '0;
            state_q[i] <= HOLD;
         end
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cur_q[i]   <= cur_d[i];
            tgt_q[i]   <= tgt_d[i];
            w_q[i]     <= w_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_servo_array.sv
// -----------------------------------------------------------------------------
// tb_pwm_servo_array
//   Directed bench for pwm_servo_array. Two instances share clock and reset:
//   dut (ANGLE_MAX=127) and dut_c (ANGLE_MAX=100, for target clamping).
//   Expected widths are hand-computed for PERIOD=2500, MIN_CYC=1000,
//   MAX_CYC=2000, STEP=16. Expectations follow PWM_SERVO_SLEW_EN when it is
//   defined for the build.
// -----------------------------------------------------------------------------
module tb_pwm_servo_array;

   localparam int PERIOD = 2500;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  enable = 3'b111;
   logic [20:0] angle_in = {7'd63, 7'd63, 7'd63};
   logic        load = 1'b0;
   logic [2:0]  pwm_out;
   logic        busy;
   logic        frame_tick;

   logic [2:0]  enable_c = 3'b111;
   logic [20:0] angle_in_c = {7'd50, 7'd50, 7'd50};
   logic        load_c = 1'b0;
   logic [2:0]  pwm_out_c;
   logic        busy_c;
   logic        frame_tick_c;

   int n_tests = 0;
   int n_fail  = 0;

   // Results of the most recent measure() call.
   int w [3];
   int wc2;
   int busy_first;

`ifdef PWM_SERVO_SLEW_EN
   int exp_w0   [4] = '{1622, 1748, 1874, 2000};
   int exp_busy [4] = '{1, 1, 1, 0};
   int exp_c2   [4] = '{1660, 1820, 1980, 2000};
   localparam int EXP_C2_DOWN1 = 1840;
   localparam int EXP_W1_LATE  = 1874;
`else
   int exp_w0   [4] = '{2000, 2000, 2000, 2000};
   int exp_busy [4] = '{0, 0, 0, 0};
   int exp_c2   [4] = '{2000, 2000, 2000, 2000};
   localparam int EXP_C2_DOWN1 = 1000;
   localparam int EXP_W1_LATE  = 1000;
`endif

   always #5 clk = ~clk;

   pwm_servo_array #(
      .NUM_CH(3), .ANGLE_W(7), .ANGLE_MAX(127), .CLK_HZ(1_000_000),
      .PWM_HZ(400), .MIN_US(1000), .MAX_US(2000), .STEP(16)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .angle_in(angle_in), .load(load),
      .pwm_out(pwm_out), .busy(busy), .frame_tick(frame_tick)
   );

   pwm_servo_array #(
      .NUM_CH(3), .ANGLE_W(7), .ANGLE_MAX(100), .CLK_HZ(1_000_000),
      .PWM_HZ(400), .MIN_US(1000), .MAX_US(2000), .STEP(16)
   ) dut_c (
      .clk(clk), .rst(rst), .enable(enable_c), .angle_in(angle_in_c), .load(load_c),
      .pwm_out(pwm_out_c), .busy(busy_c), .frame_tick(frame_tick_c)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called on a negedge. Waits for frame_tick, then counts high cycles of each
   // pulse over the following frame. Optionally toggles enable[0] at a sample
   // index or asserts load on the frame_tick cycle itself.
   task automatic measure(input int off_at, input int on_at, input bit do_load);
      int guard;
      int nt;
      int last;
      guard = 0;
      while (!frame_tick && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check("tick_wait", int'(frame_tick), 1);
      if (do_load) load = 1'b1;
      w = '{0, 0, 0};
      wc2 = 0;
      nt = 0;
      last = 0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         load = 1'b0;
         if (i == 0) busy_first = int'(busy);
         for (int ch = 0; ch < 3; ch++) w[ch] += int'(pwm_out[ch]);
         wc2 += int'(pwm_out_c[2]);
         nt += int'(frame_tick);
         last = int'(frame_tick);
         if (i == off_at) enable[0] = 1'b0;
         if (i == on_at)  enable[0] = 1'b1;
      end
      check("tick_count", nt, 1);
      check("tick_last", last, 1);
   endtask

   // Mid-frame load strobe on one of the two instances.
   task automatic load_mid(input bit on_c);
      repeat (100) @(negedge clk);
      if (on_c) load_c = 1'b1; else load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      load_c = 1'b0;
   endtask

   initial begin
      int cyc;
      int hi;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_tick", int'(frame_tick), 0);
      check("rst_busy", int'(busy), 0);

      // Frame 0: no pulse until the first boundary
      rst = 1'b1;
      cyc = 0;
      hi = 0;
      while (!frame_tick && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         hi += int'(|pwm_out);
      end
      check("frame0_len", cyc, PERIOD - 1);
      check("frame0_pulse", hi, 0);

      // Frame 1: angle 63 -> 1496 cycles, dut_c angle 50 -> 1500
      measure(-1, -1, 1'b0);
      check("f1_w0", w[0], 1496);
      check("f1_w1", w[1], 1496);
      check("f1_w2", w[2], 1496);
      check("f1_c2", wc2, 1500);

      // ch0/ch1 -> 127 on dut; ch2 -> 0x7F (clamped to 100) on dut_c
      angle_in   = {7'd63, 7'd127, 7'd127};
      angle_in_c = {7'h7F, 7'd50, 7'd50};
      repeat (100) @(negedge clk);
      load = 1'b1;
      load_c = 1'b1;
      @(negedge clk);
      load = 1'b0;
      load_c = 1'b0;
      check("busy_after_load", int'(busy), 1);
      for (int k = 0; k < 4; k++) begin
         measure(-1, -1, 1'b0);
         check($sformatf("ramp_w0_f%0d", k), w[0], exp_w0[k]);
         check($sformatf("ramp_w1_f%0d", k), w[1], exp_w0[k]);
         check($sformatf("ramp_busy_f%0d", k), busy_first, exp_busy[k]);
         check($sformatf("clamp_c2_f%0d", k), wc2, exp_c2[k]);
      end

      // dut_c ch2 -> 0
      angle_in_c = {7'd0, 7'd50, 7'd50};
      load_mid(1'b1);

      // Enable drop mid-pulse, then re-enable mid-frame
      measure(500, -1, 1'b0);
      check("en_drop_full", w[0], 2000);
      check("c2_down_f0", wc2, EXP_C2_DOWN1);
      measure(-1, 500, 1'b0);
      check("en_off_frame", w[0], 0);
      measure(-1, -1, 1'b0);
      check("en_resume", w[0], 2000);

      // Load on the frame_tick cycle: ch1 -> 0 only one frame later
      angle_in = {7'd63, 7'd0, 7'd127};
      measure(-1, -1, 1'b1);
      check("tick_load_same", w[1], 2000);
      check("tick_load_busy", busy_first, 1);
      measure(-1, -1, 1'b0);
      check("tick_load_next", w[1], EXP_W1_LATE);
      check("tick_load_w0", w[0], 2000);

      // Let dut_c ch2 finish its descent to angle 0
      measure(-1, -1, 1'b0);
      measure(-1, -1, 1'b0);
      check("c2_reach_min", wc2, 1000);

      // Reset asserted mid-pulse
      repeat (100) @(negedge clk);
      check("pre_rst_pwm0", int'(pwm_out[0]), 1);
      rst = 1'b0;
      #1;
      check("mid_rst_pwm", int'(pwm_out), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_tick", int'(frame_tick), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
